// File: rtl/bram_medium_pkg.sv
// bram_medium_pkg
//   Shared types and helpers for the BRAM medium and the blocks that talk to it.
//   - seq_state_t      : sequencer FSM states
//   - MED_OP_READ/WRITE: encoding of the latched command direction
//   - addr_size()      : slot address width for a given slot count
//   - vector_width()   : full vector width from piece count and piece width
package bram_medium_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } seq_state_t;

  localparam logic MED_OP_READ  = 1'b0;
  localparam logic MED_OP_WRITE = 1'b1;

  // A single-slot medium still needs a 1-bit address port.
  function automatic int addr_size(input int addrs);
    return (addrs > 1) ? $clog2(addrs) : 1;
  endfunction

  function automatic int vector_width(input int pieces, input int bram_width);
    return pieces * bram_width;
  endfunction

endpackage

// File: rtl/bram_medium_sequencer_watchdog.sv
// cycle_watchdog
//   Counts enabled cycles since the last clear and flags the LIMIT-th one.
//   Ports:
//     clk_in, rst_in : clock, asynchronous active-high reset
//     clear          : restart the count from zero (wins over enable)
//     enable         : count this cycle
//     expired        : high during the LIMIT-th consecutive enabled cycle
//   The counter saturates at LIMIT and never wraps.
module cycle_watchdog #(
  parameter int LIMIT = 256
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);
  localparam logic [CW-1:0] MAX  = CW'(LIMIT);

  logic [CW-1:0] count;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != MAX)) begin
      count <= count + 1'b1;
    end
  end

  // count holds the number of enabled cycles already completed, so the
  // cycle seeing LAST is the LIMIT-th one; flag it so the owner can act
  // at the end of exactly LIMIT cycles.
  assign expired = enable && (count >= LAST);

endmodule

// File: rtl/bram_medium_sequencer.sv
// bram_medium_sequencer
//   Turns whole-vector read/write commands into the BRAM medium's pulse
//   handshake and returns exactly one response per command.
//   Ports:
//     clk_in, rst_in          : clock, asynchronous active-high reset
//     cmd_valid_in/ready_out  : command stream handshake
//     cmd_write_in, cmd_addr_in, cmd_data_in : command payload
//     rsp_valid_out/ready_in  : response stream handshake
//     rsp_write_out, rsp_error_out, rsp_data_out : response payload
//     med_*_out / med_*_in    : medium user port
//     busy_out                : a command is in flight
module bram_medium_sequencer
  import bram_medium_pkg::*;
#(
  parameter int ADDRS          = 1024,
  parameter int BRAM_WIDTH     = 64,
  parameter int PIECES         = 32,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int ADDR_SIZE      = addr_size(ADDRS),
  parameter int WIDTH          = vector_width(PIECES, BRAM_WIDTH)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 cmd_valid_in,
  output logic                 cmd_ready_out,
  input  logic                 cmd_write_in,
  input  logic [ADDR_SIZE-1:0] cmd_addr_in,
  input  logic [WIDTH-1:0]     cmd_data_in,
  output logic                 rsp_valid_out,
  input  logic                 rsp_ready_in,
  output logic                 rsp_write_out,
  output logic                 rsp_error_out,
  output logic [WIDTH-1:0]     rsp_data_out,
  output logic [ADDR_SIZE-1:0] med_addr_out,
  output logic [WIDTH-1:0]     med_data_out,
  output logic                 med_write_enable_out,
  output logic                 med_read_enable_out,
  input  logic [WIDTH-1:0]     med_data_in,
  input  logic                 med_finished_in,
  output logic                 busy_out
);

  seq_state_t           state;
  logic                 ready_q;
  logic                 op_q;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [WIDTH-1:0]     data_q;
  logic                 rsp_write_q;
  logic                 rsp_error_q;
  logic [WIDTH-1:0]     rsp_data_q;
  logic                 timeout;

  // Held clear for the whole idle period so every command starts from zero;
  // it only advances while the medium owes a finished pulse.
  cycle_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .clear  (state == IDLE),
    .enable (state == WAIT),
    .expired(timeout)
  );

  // ready_q is a flop rather than a state decode so it reads 0 during reset
  // even though reset parks the FSM in IDLE. It comes up one cycle after
  // reset release and drops on the accepting edge.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state       <= IDLE;
      ready_q     <= 1'b0;
      op_q        <= MED_OP_READ;
      addr_q      <= '0;
      data_q      <= '0;
      rsp_write_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          ready_q <= 1'b1;
          if (cmd_valid_in && ready_q) begin
            op_q        <= cmd_write_in ? MED_OP_WRITE : MED_OP_READ;
            addr_q      <= cmd_addr_in;
            data_q      <= cmd_data_in;
            rsp_write_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_data_q  <= '0;
            ready_q     <= 1'b0;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          // A real finished pulse wins over a same-cycle timeout.
          if (med_finished_in) begin
            rsp_data_q  <= (op_q == MED_OP_WRITE) ? '0 : med_data_in;
            rsp_write_q <= op_q;
            rsp_error_q <= 1'b0;
            state       <= RESP;
          end else if (timeout) begin
            rsp_data_q  <= '0;
            rsp_write_q <= op_q;
            rsp_error_q <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready_in) begin
            ready_q <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Enables are decoded from the state register, giving a one-cycle pulse
  // with no path from the command or response inputs.
  assign med_write_enable_out = (state == ISSUE) && (op_q == MED_OP_WRITE);
  assign med_read_enable_out  = (state == ISSUE) && (op_q == MED_OP_READ);
  assign med_addr_out         = addr_q;
  assign med_data_out         = data_q;

  assign cmd_ready_out = ready_q;
  assign rsp_valid_out = (state == RESP);
  assign rsp_write_out = rsp_write_q;
  assign rsp_error_out = rsp_error_q;
  assign rsp_data_out  = rsp_data_q;
  assign busy_out      = (state != IDLE);

endmodule

// File: tb/tb_bram_medium_sequencer.sv
// tb_bram_medium_sequencer
//   Drives directed commands into bram_medium_sequencer against a simple
//   behavioural medium (fixed latency, optional stub that never finishes).
//   Expected responses go into a queue; a monitor pops one per response
//   handshake and compares.
module tb_bram_medium_sequencer;

  localparam int ADDRS      = 16;
  localparam int BRAM_WIDTH = 8;
  localparam int PIECES     = 4;
  localparam int TIMEOUT    = 64;
  localparam int AW         = 4;
  localparam int W          = 32;
  localparam int MED_LAT    = 6;

  logic          clk_in;
  logic          rst_in;
  logic          cmd_valid_in;
  logic          cmd_ready_out;
  logic          cmd_write_in;
  logic [AW-1:0] cmd_addr_in;
  logic [W-1:0]  cmd_data_in;
  logic          rsp_valid_out;
  logic          rsp_ready_in;
  logic          rsp_write_out;
  logic          rsp_error_out;
  logic [W-1:0]  rsp_data_out;
  logic [AW-1:0] med_addr_out;
  logic [W-1:0]  med_data_out;
  logic          med_write_enable_out;
  logic          med_read_enable_out;
  logic [W-1:0]  med_data_in;
  logic          med_finished_in;
  logic          busy_out;

  bram_medium_sequencer #(
    .ADDRS(ADDRS),
    .BRAM_WIDTH(BRAM_WIDTH),
    .PIECES(PIECES),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .cmd_valid_in(cmd_valid_in),
    .cmd_ready_out(cmd_ready_out),
    .cmd_write_in(cmd_write_in),
    .cmd_addr_in(cmd_addr_in),
    .cmd_data_in(cmd_data_in),
    .rsp_valid_out(rsp_valid_out),
    .rsp_ready_in(rsp_ready_in),
    .rsp_write_out(rsp_write_out),
    .rsp_error_out(rsp_error_out),
    .rsp_data_out(rsp_data_out),
    .med_addr_out(med_addr_out),
    .med_data_out(med_data_out),
    .med_write_enable_out(med_write_enable_out),
    .med_read_enable_out(med_read_enable_out),
    .med_data_in(med_data_in),
    .med_finished_in(med_finished_in),
    .busy_out(busy_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic         write;
    logic         error;
    logic [W-1:0] data;
  } rsp_t;

  rsp_t expq[$];
  int   testsRun    = 0;
  int   testsFailed = 0;
  int   enCount     = 0;
  logic prevEn      = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Behavioural medium: takes an enable only while idle, writes memory on
  // acceptance, pulses finished MED_LAT edges later. stubMode makes it
  // ignore enables entirely; stubPulse injects a stray finished.
  logic [W-1:0]  mem [ADDRS];
  int            medCnt;
  logic          modelFin;
  logic [W-1:0]  modelData;
  logic [AW-1:0] pendAddr;
  logic          pendRead;
  logic          stubMode;
  logic          stubPulse;

  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      medCnt    <= 0;
      modelFin  <= 1'b0;
      modelData <= '0;
      pendAddr  <= '0;
      pendRead  <= 1'b0;
    end else begin
      modelFin <= 1'b0;
      if (medCnt == 0) begin
        if (!stubMode && (med_write_enable_out || med_read_enable_out)) begin
          medCnt   <= MED_LAT;
          pendAddr <= med_addr_out;
          pendRead <= med_read_enable_out;
          if (med_write_enable_out) mem[med_addr_out] <= med_data_out;
        end
      end else if (medCnt == 1) begin
        medCnt    <= 0;
        modelFin  <= 1'b1;
        modelData <= pendRead ? mem[pendAddr] : '0;
      end else begin
        medCnt <= medCnt - 1;
      end
    end
  end

  assign med_finished_in = modelFin | stubPulse;
  assign med_data_in     = modelData;

  // Scoreboard monitor: one pop per accepted response.
  always @(negedge clk_in) begin
    rsp_t e;
    if (!rst_in && rsp_valid_out && rsp_ready_in) begin
      if (expq.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected_rsp: got write=%0b error=%0b data=%0h, expected no response",
                 rsp_write_out, rsp_error_out, rsp_data_out);
      end else begin
        e = expq.pop_front();
        checkOutput("rsp_write", 64'(rsp_write_out), 64'(e.write));
        checkOutput("rsp_error", 64'(rsp_error_out), 64'(e.error));
        checkOutput("rsp_data", 64'(rsp_data_out), 64'(e.data));
      end
    end
  end

  // Enable pulses must be exclusive and one cycle wide; ready must be low
  // whenever a command is in flight.
  always @(negedge clk_in) begin
    if (med_write_enable_out || med_read_enable_out) begin
      checkOutput("en_exclusive", 64'(med_write_enable_out & med_read_enable_out), 64'd0);
      checkOutput("en_width", 64'(prevEn), 64'd0);
      enCount++;
    end
    if (busy_out) checkOutput("ready_low_busy", 64'(cmd_ready_out), 64'd0);
    prevEn = med_write_enable_out | med_read_enable_out;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr,
                               input logic [W-1:0] data, input logic expErr,
                               input logic [W-1:0] expData, input bit push);
    rsp_t e;
    int   waited;
    if (push) begin
      e.write = wr;
      e.error = expErr;
      e.data  = expData;
      expq.push_back(e);
    end
    @(posedge clk_in); #1;
    cmd_valid_in = 1'b1;
    cmd_write_in = wr;
    cmd_addr_in  = addr;
    cmd_data_in  = data;
    waited = 0;
    @(negedge clk_in);
    while (!cmd_ready_out && waited < 300) begin
      @(negedge clk_in);
      waited++;
    end
    if (waited >= 300) checkOutput("accept_timeout", 64'(waited), 64'd0);
    @(posedge clk_in); #1;
    cmd_valid_in = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((expq.size() != 0 || busy_out) && n < 300) begin
      @(negedge clk_in);
      n++;
    end
    checkOutput("drain_timeout", 64'(n >= 300), 64'd0);
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_ctrl"}, 64'({cmd_ready_out, rsp_valid_out, rsp_write_out, rsp_error_out,
                                      med_write_enable_out, med_read_enable_out, busy_out,
                                      med_addr_out}), 64'd0);
    checkOutput({name, "_data"}, 64'(rsp_data_out | med_data_out), 64'd0);
  endtask

  initial begin
    int snap;
    int n;
    rst_in       = 1'b1;
    cmd_valid_in = 1'b0;
    cmd_write_in = 1'b0;
    cmd_addr_in  = '0;
    cmd_data_in  = '0;
    rsp_ready_in = 1'b1;
    stubMode     = 1'b0;
    stubPulse    = 1'b0;

    // Reset state
    repeat (2) @(negedge clk_in);
    checkAllZero("reset");
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    repeat (2) @(negedge clk_in);
    checkOutput("post_reset_ready", 64'(cmd_ready_out), 64'd1);
    checkOutput("post_reset_busy", 64'(busy_out), 64'd0);

    // 1: write then read slot 3
    applyStimulus(1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 4'd3, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1);
    waitDrain();

    // 2: back-to-back write/read of slot 5
    snap = enCount;
    applyStimulus(1'b1, 4'd5, 32'h01234567, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 4'd5, 32'h0, 1'b0, 32'h01234567, 1'b1);
    waitDrain();
    checkOutput("t2_enable_count", 64'(enCount - snap), 64'd2);

    // 3: consumer stalls for 10 cycles while another command waits
    @(posedge clk_in); #1;
    rsp_ready_in = 1'b0;
    applyStimulus(1'b0, 4'd3, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1);
    n = 0;
    while (!rsp_valid_out && n < 200) begin
      @(negedge clk_in);
      n++;
    end
    checkOutput("t3_rsp_arrived", 64'(rsp_valid_out), 64'd1);
    @(posedge clk_in); #1;
    cmd_valid_in = 1'b1;
    cmd_write_in = 1'b1;
    cmd_addr_in  = 4'd7;
    cmd_data_in  = 32'hCAFEF00D;
    snap = enCount;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in);
      checkOutput("t3_hold_valid", 64'(rsp_valid_out), 64'd1);
      checkOutput("t3_hold_data", 64'(rsp_data_out), 64'(32'hDEADBEEF));
      checkOutput("t3_hold_ready", 64'(cmd_ready_out), 64'd0);
    end
    @(posedge clk_in); #1;
    cmd_valid_in = 1'b0;
    rsp_ready_in = 1'b1;
    waitDrain();
    checkOutput("t3_no_new_cmd", 64'(enCount - snap), 64'd0);

    // 4: medium never finishes -> watchdog error, stray pulse ignored
    @(posedge clk_in); #1;
    stubMode = 1'b1;
    applyStimulus(1'b0, 4'd2, 32'h0, 1'b1, 32'h0, 1'b1);
    @(negedge clk_in);
    checkOutput("t4_issue", 64'(med_read_enable_out), 64'd1);
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (!rsp_valid_out && n < 200);
    checkOutput("t4_wait_cycles", 64'(n - 1), 64'd64);
    repeat (3) @(negedge clk_in);
    @(posedge clk_in); #1;
    stubPulse = 1'b1;
    @(posedge clk_in); #1;
    stubPulse = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      checkOutput("t4_late_pulse_valid", 64'(rsp_valid_out), 64'd0);
      checkOutput("t4_late_pulse_busy", 64'(busy_out), 64'd0);
    end
    stubMode = 1'b0;
    waitDrain();

    // 5: asynchronous reset in the middle of a read
    applyStimulus(1'b0, 4'd3, 32'h0, 1'b0, 32'h0, 1'b0);
    repeat (3) @(negedge clk_in);
    checkOutput("t5_in_wait", 64'(busy_out), 64'd1);
    #2;
    rst_in = 1'b1;
    #1;
    checkAllZero("t5_async_reset");
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    repeat (2) @(negedge clk_in);
    checkOutput("t5_ready", 64'(cmd_ready_out), 64'd1);
    checkOutput("t5_idle", 64'(busy_out), 64'd0);
    checkOutput("t5_no_rsp", 64'(rsp_valid_out), 64'd0);
    applyStimulus(1'b1, 4'd0, 32'h0000FFFF, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 32'h0000FFFF, 1'b1);
    waitDrain();

    // 6: command pressure while busy must not be latched
    snap = enCount;
    applyStimulus(1'b0, 4'd5, 32'h0, 1'b0, 32'h01234567, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cmd_valid_in = 1'b1;
      cmd_write_in = i[0];
      cmd_addr_in  = 4'd9;
      cmd_data_in  = W'(i);
      @(negedge clk_in);
      if (busy_out) checkOutput("t6_addr_stable", 64'(med_addr_out), 64'd5);
      @(posedge clk_in); #1;
    end
    cmd_valid_in = 1'b0;
    waitDrain();
    checkOutput("t6_enable_count", 64'(enCount - snap), 64'd1);

    repeat (3) @(negedge clk_in);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
